ssd_bcd_driver: RTL and testbench
=================================

SSD_BCD_DRIVER -- requirements
Module: ssd_bcd_driver

Interface
REQ-001 SHALL have parameter: REFRESH_BITS, 18, width of the free-running refresh counter; the top 2 bits select the active digit (tests use 4).
REQ-002 SHALL have port: clk  input  1  single system clock; every flop is rising-edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: value  input  13  unsigned binary value to display (0..8191), the CPU's SSD debug word.
REQ-005 SHALL have port: blank_lz  input  1  1 = blank leading zeros.
REQ-006 SHALL have port: anode  output  4  digit enables, active-low, one-hot; anode[0] = ones (rightmost).
REQ-007 SHALL have port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port: dp  output  1  decimal point, active-low; held at 1 (off).
REQ-009 SHALL have port: busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-010 SHALL hold four internal registers: held (13b, last converted value), disp (16b, four committed BCD digits), shift register (13b binary + 16b BCD), step counter (4b).
REQ-011 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-012 In IDLE with value != held, the next edge SHALL load value into the binary part, clear the BCD part, zero the step counter, and enter SHIFT.
REQ-013 In IDLE with value == held, the FSM SHALL stay in IDLE.
REQ-014 Each SHIFT edge SHALL add 3 to every BCD nibble >= 5, then shift the 29-bit {BCD,binary} left by one and increment the step counter.
REQ-015 After the 13th shift (step counter = 12 on that edge) the FSM SHALL enter DONE.
REQ-016 The DONE edge SHALL copy the BCD part to disp, copy the captured binary value to held, and return to IDLE.
REQ-017 Latency SHALL be exactly 15 edges from the first edge seeing value != held in IDLE to disp updated: capture on edge 1, shifts on edges 2-14, commit on edge 15.
REQ-018 busy SHALL be registered and high exactly while the state is SHIFT or DONE (14 cycles per conversion).
REQ-019 Changes to value while busy SHALL be ignored by the running conversion; the stale result commits, and the IDLE compare then starts a new conversion on the following edge.
REQ-020 disp SHALL change only on the DONE edge; the display never shows partial BCD.
REQ-021 The thousands digit SHALL be in 0..8; all arithmetic SHALL be unsigned with no overflow path.
REQ-022 The refresh counter SHALL increment every edge, wrap from all-ones to 0, and have its top 2 bits give digit index d (0 = ones .. 3 = thousands).
REQ-023 anode and seg SHALL be registered from d and disp each edge, one cycle behind the counter.
REQ-024 anode SHALL be ~(4'b0001 << d).
REQ-025 seg encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other nibble = 1111111.
REQ-026 With blank_lz=1: thousands is blanked if 0; hundreds is blanked if thousands and hundreds are 0; tens is blanked if thousands, hundreds and tens are 0; ones is never blanked.
REQ-027 A blanked digit SHALL still scan its anode but drive seg = 1111111.

Reset
REQ-028 While rst=0, outputs SHALL be immediately: anode=1111, seg=1111111, dp=1, busy=0.
REQ-029 While rst=0, internal state SHALL be: refresh counter=0, disp=0, held=0, FSM=IDLE, step counter=0.
REQ-030 Reset asserted mid-conversion SHALL abort it without committing.
REQ-031 After rst rises, the first edge SHALL give anode=1110, seg=1000000; since value=0 matches held=0, no conversion starts.

Verification (REFRESH_BITS=4)
REQ-032 Reset release with value=0, blank_lz=1 -> anode scans 1110,1101,1011,0111 at 4 cycles each; seg=1000000 on anode 1110, 1111111 elsewhere; busy stays 0.
REQ-033 value 0 -> 8191 -> busy high 14 cycles; disp=8191 on edge 15; seg per digit: ones 1111001, tens 0010000, hundreds 1111001, thousands 0000000.
REQ-034 value=100, then 4096 on the 5th busy cycle -> 0100 commits; busy drops for 1 cycle, reasserts, and 4096 commits 15 edges later.
REQ-035 rst pulsed low on busy cycle 7 of converting 1234 -> outputs reset asynchronously; after release, reconversion yields 1234 15 edges later.
REQ-036 blank_lz=1, value=7 -> seg=1111000 on anode 1110, 1111111 on the others; blank_lz=0 -> seg=1000000 on the other three.

Source files
------------

// File: rtl/ssd_bcd_driver.sv
// Four-digit seven-segment driver: converts a 13-bit binary value to BCD
// with a sequential double-dabble engine, then multiplexes the digits onto an active-low display.
module ssd_bcd_driver #(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    input  logic        blank_lz,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [REFRESH_BITS-1:0] CNT_ONE = 1;

    state_t                  state, stateNext;
    logic [12:0]             held, heldNext;
    logic [12:0]             capVal, capNext;
    logic [15:0]             disp, dispNext;
    logic [15:0]             bcd, bcdNext, adj;
    logic [12:0]             bin, binNext;
    logic [3:0]              step, stepNext;
    logic [REFRESH_BITS-1:0] refreshCnt;
    logic [1:0]              digitIdx;
    logic [3:0]              curDigit;
    logic                    blankDigit;
    logic [3:0]              anodeNext;
    logic [6:0]              segNext;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        stateNext = state;
        heldNext  = held;
        capNext   = capVal;
        dispNext  = disp;
        bcdNext   = bcd;
        binNext   = bin;
        stepNext  = step;
        adj       = bcd;
        case (state)
            IDLE: begin
                if (value != held) begin
                    binNext   = value;
                    capNext   = value;
                    bcdNext   = '0;
                    stepNext  = '0;
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
                end
                {bcdNext, binNext} = {adj[14:0], bin, 1'b0};
                stepNext = step + 4'd1;
                if (step == 4'd12) stateNext = DONE;
            end
            DONE: begin
                dispNext  = bcd;
                heldNext  = capVal;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Leading-zero blanking cascades downward from the thousands digit; ones always shows.
    assign digitIdx = refreshCnt[REFRESH_BITS-1 -: 2];

    always_comb begin
        curDigit   = disp[3:0];
        blankDigit = 1'b0;
        case (digitIdx)
            2'd0: curDigit = disp[3:0];
            2'd1: begin
                curDigit   = disp[7:4];
                blankDigit = blank_lz && (disp[15:4] == 12'd0);
            end
            2'd2: begin
                curDigit   = disp[11:8];
                blankDigit = blank_lz && (disp[15:8] == 8'd0);
            end
            default: begin
                curDigit   = disp[15:12];
                blankDigit = blank_lz && (disp[15:12] == 4'd0);
            end
        endcase
        anodeNext = ~(4'b0001 << digitIdx);
        segNext   = blankDigit ? '1 : decode(curDigit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            held       <= '0;
            capVal     <= '0;
            disp       <= '0;
            bcd        <= '0;
            bin        <= '0;
            step       <= '0;
            busy       <= 1'b0;
            refreshCnt <= '0;
            anode      <= '1;
            seg        <= '1;
        end else begin
            state      <= stateNext;
            held       <= heldNext;
            capVal     <= capNext;
            disp       <= dispNext;
            bcd        <= bcdNext;
            bin        <= binNext;
            step       <= stepNext;
            busy       <= (stateNext != IDLE);
            refreshCnt <= refreshCnt + CNT_ONE;
            anode      <= anodeNext;
            seg        <= segNext;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// Self-checking bench for ssd_bcd_driver (REFRESH_BITS=4): directed scenarios plus
// random values, checked every cycle against a decimal-arithmetic reference model.
module tb_ssd_bcd_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value;
    logic        blank_lz;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int nTests = 0;
    int nFail  = 0;

    int mCnt, mDisp, mHeld, mCap, mEdge;
    bit mActive;

    always #5 clk = ~clk;

    ssd_bcd_driver #(.REFRESH_BITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .blank_lz (blank_lz),
        .anode    (anode),
        .seg      (seg),
        .dp       (dp),
        .busy     (busy)
    );

    function automatic logic [6:0] segOf(input int n);
        case (n)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // A digit above the ones is a leading zero exactly when the value is below 10**d.
    function automatic logic [6:0] expSeg(input int d, input int v, input bit bl);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (bl && d > 0 && v < p) return 7'b1111111;
        return segOf((v / p) % 10);
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkReset();
        check("rst_anode", {3'b000, anode}, 7'b0001111);
        check("rst_seg", seg, 7'b1111111);
        check("rst_dp", {6'd0, dp}, 7'd1);
        check("rst_busy", {6'd0, busy}, 7'd0);
    endtask

    task automatic modelReset();
        mCnt    = 0;
        mDisp   = 0;
        mHeld   = 0;
        mCap    = 0;
        mEdge   = 0;
        mActive = 0;
    endtask

    task automatic tick();
        int d;
        logic [3:0] eAn;
        logic [6:0] eSeg;
        d    = (mCnt >> 2) & 3;
        eAn  = ~(4'b0001 << d);
        eSeg = expSeg(d, mDisp, blank_lz);
        if (!mActive) begin
            if (int'(value) != mHeld) begin
                mActive = 1;
                mCap    = int'(value);
                mEdge   = 1;
            end
        end else begin
            mEdge++;
            if (mEdge == 15) begin
                mDisp   = mCap;
                mHeld   = mCap;
                mActive = 0;
            end
        end
        mCnt = (mCnt + 1) % 16;
        @(posedge clk);
        #1;
        check("anode", {3'b000, anode}, {3'b000, eAn});
        check("seg", seg, eSeg);
        check("busy", {6'd0, busy}, {6'd0, mActive});
        check("dp", {6'd0, dp}, 7'd1);
    endtask

    initial begin
        rst      = 1'b0;
        value    = '0;
        blank_lz = 1'b1;
        modelReset();
        #12;
        checkReset();
        @(posedge clk);
        #1;
        checkReset();
        rst = 1'b1;

        // Idle scan of zero with blanking, no conversion expected
        repeat (20) tick();

        // Full-scale value
        value = 13'd8191;
        repeat (40) tick();

        // Value change on the 5th busy cycle is deferred to a second conversion
        value = 13'd100;
        tick();
        repeat (4) tick();
        value = 13'd4096;
        repeat (40) tick();

        // Blanking on/off with a single-digit value
        value = 13'd7;
        repeat (40) tick();
        blank_lz = 1'b0;
        repeat (20) tick();
        blank_lz = 1'b1;

        // Asynchronous reset in the middle of a conversion
        value = 13'd1234;
        repeat (7) tick();
        rst = 1'b0;
        #2;
        checkReset();
        modelReset();
        rst = 1'b1;
        repeat (40) tick();

        // Random values, blanking modes and hold times, including changes while busy
        repeat (40) begin
            value    = 13'($urandom_range(0, 8191));
            blank_lz = 1'($urandom);
            repeat ($urandom_range(1, 25)) tick();
        end
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
